// File: rtl/argmax_pkg.sv
// Shared constants and FSM state type for the argmax classifier.
package argmax_pkg;

   localparam int N_CLASSES_DEF = 10;
   localparam int PROB_W        = 16;
   localparam int IDX_W         = 4;
   localparam int FRAC_BITS     = 11;
   localparam logic [PROB_W-1:0] ONE = PROB_W'(1) << FRAC_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational best/second-best update for one candidate element.
// Second-best tracking exists only when ARGMAX_MARGIN_EN is defined.
module argmax_cmp
   import argmax_pkg::*;
(
   input  logic [PROB_W-1:0] cand_val,
   input  logic [IDX_W-1:0]  cand_idx,
   input  logic [PROB_W-1:0] best_val,
   input  logic [IDX_W-1:0]  best_idx,
`ifdef ARGMAX_MARGIN_EN
   input  logic [PROB_W-1:0] sec_val,
   input  logic [IDX_W-1:0]  sec_idx,
   output logic [PROB_W-1:0] sec_val_out,
   output logic [IDX_W-1:0]  sec_idx_out,
`endif
   output logic [PROB_W-1:0] best_val_out,
   output logic [IDX_W-1:0]  best_idx_out
);

   // Strictly greater keeps the earliest index on ties.
   logic take_best;
   assign take_best = cand_val > best_val;

   always_comb begin
      best_val_out = best_val;
      best_idx_out = best_idx;
      if (take_best) begin
         best_val_out = cand_val;
         best_idx_out = cand_idx;
      end
   end

`ifdef ARGMAX_MARGIN_EN
   always_comb begin
      sec_val_out = sec_val;
      sec_idx_out = sec_idx;
      if (take_best) begin
         sec_val_out = best_val;
         sec_idx_out = best_idx;
      end else if (cand_val > sec_val) begin
         sec_val_out = cand_val;
         sec_idx_out = cand_idx;
      end
   end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over N_CLASSES snapshotted probabilities, one element per cycle.
// Define ARGMAX_MARGIN_EN to add runner-up, margin and low-confidence outputs.
module argmax_classifier
   import argmax_pkg::*;
#(
   parameter int                N_CLASSES   = N_CLASSES_DEF,
   parameter logic [PROB_W-1:0] CONF_THRESH = ONE >> 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Ready,
   input  logic [N_CLASSES*PROB_W-1:0] Probability,
   output logic                        Busy,
   output logic                        Done,
   output logic                        Valid,
   output logic [IDX_W-1:0]            Digit,
   output logic [PROB_W-1:0]           Confidence,
   output logic [IDX_W-1:0]            Runner,
   output logic [PROB_W-1:0]           Margin,
   output logic                        LowConf
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

   state_t            state_reg, state_next;
   logic              ready_reg;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [PROB_W-1:0] best_val_reg, best_val_next;
   logic [IDX_W-1:0]  best_idx_reg, best_idx_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              valid_reg, valid_next;
   logic [IDX_W-1:0]  digit_reg, digit_next;
   logic [PROB_W-1:0] conf_reg, conf_next;
   logic [PROB_W-1:0] snap_reg [N_CLASSES];
   logic [PROB_W-1:0] cand_val;
   logic [PROB_W-1:0] cmp_best_val;
   logic [IDX_W-1:0]  cmp_best_idx;
   logic              start;
   logic              load_snap;

   assign start     = Ready & ~ready_reg;
   assign load_snap = (state_reg == ST_IDLE) && start;
   assign cand_val  = snap_reg[idx_reg];

   generate
      for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_snap
         always_ff @(posedge Clk) begin
            if (load_snap) begin
               snap_reg[gi] <= Probability[gi*PROB_W +: PROB_W];
            end
         end
      end
   endgenerate

`ifdef ARGMAX_MARGIN_EN
   logic [PROB_W-1:0] sec_val_reg, sec_val_next;
   logic [IDX_W-1:0]  sec_idx_reg, sec_idx_next;
   logic [PROB_W-1:0] cmp_sec_val;
   logic [IDX_W-1:0]  cmp_sec_idx;
   logic [IDX_W-1:0]  runner_reg, runner_next;
   logic [PROB_W-1:0] margin_reg, margin_next;
   logic              lowconf_reg, lowconf_next;
`endif

   argmax_cmp u_cmp (
      .cand_val     (cand_val),
      .cand_idx     (idx_reg),
      .best_val     (best_val_reg),
      .best_idx     (best_idx_reg),
`ifdef ARGMAX_MARGIN_EN
      .sec_val      (sec_val_reg),
      .sec_idx      (sec_idx_reg),
      .sec_val_out  (cmp_sec_val),
      .sec_idx_out  (cmp_sec_idx),
`endif
      .best_val_out (cmp_best_val),
      .best_idx_out (cmp_best_idx)
   );

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      best_val_next = best_val_reg;
      best_idx_next = best_idx_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      valid_next    = valid_reg;
      digit_next    = digit_reg;
      conf_next     = conf_reg;
`ifdef ARGMAX_MARGIN_EN
      sec_val_next  = sec_val_reg;
      sec_idx_next  = sec_idx_reg;
      runner_next   = runner_reg;
      margin_next   = margin_reg;
      lowconf_next  = lowconf_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               idx_next   = '0;
               busy_next  = 1'b1;
               valid_next = 1'b0;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // Element 0 seeds the best; the runner-up starts at value 0, index 0.
            if (idx_reg == '0) begin
               best_val_next = cand_val;
               best_idx_next = '0;
`ifdef ARGMAX_MARGIN_EN
               sec_val_next  = '0;
               sec_idx_next  = '0;
`endif
            end else begin
               best_val_next = cmp_best_val;
               best_idx_next = cmp_best_idx;
`ifdef ARGMAX_MARGIN_EN
               sec_val_next  = cmp_sec_val;
               sec_idx_next  = cmp_sec_idx;
`endif
            end
            idx_next = idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            digit_next   = best_idx_reg;
            conf_next    = best_val_reg;
`ifdef ARGMAX_MARGIN_EN
            runner_next  = sec_idx_reg;
            margin_next  = best_val_reg - sec_val_reg;
            lowconf_next = best_val_reg < CONF_THRESH;
`endif
            done_next    = 1'b1;
            valid_next   = 1'b1;
            busy_next    = 1'b0;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= ST_IDLE;
         ready_reg    <= 1'b0;
         idx_reg      <= '0;
         best_val_reg <= '0;
         best_idx_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         digit_reg    <= '0;
         conf_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         ready_reg    <= Ready;
         idx_reg      <= idx_next;
         best_val_reg <= best_val_next;
         best_idx_reg <= best_idx_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         valid_reg    <= valid_next;
         digit_reg    <= digit_next;
         conf_reg     <= conf_next;
      end
   end

`ifdef ARGMAX_MARGIN_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sec_val_reg <= '0;
         sec_idx_reg <= '0;
         runner_reg  <= '0;
         margin_reg  <= '0;
         lowconf_reg <= 1'b0;
      end else begin
         sec_val_reg <= sec_val_next;
         sec_idx_reg <= sec_idx_next;
         runner_reg  <= runner_next;
         margin_reg  <= margin_next;
         lowconf_reg <= lowconf_next;
      end
   end

   assign Runner  = runner_reg;
   assign Margin  = margin_reg;
   assign LowConf = lowconf_reg;
`else
   assign Runner  = '0;
   assign Margin  = '0;
   assign LowConf = 1'b0;
`endif

   assign Busy       = busy_reg;
   assign Done       = done_reg;
   assign Valid      = valid_reg;
   assign Digit      = digit_reg;
   assign Confidence = conf_reg;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes expected results, a monitor checks each Done.
module tb_argmax_classifier;
   import argmax_pkg::*;

   localparam int NC = 10;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic             Ready = 1'b0;
   logic [NC*16-1:0] prob = '0;
   logic             Busy, Done, Valid, LowConf;
   logic [3:0]       Digit, Runner;
   logic [15:0]      Confidence, Margin;

   int cyc   = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      string name;
      int    cyc;
      int    digit;
      int    conf;
      int    runner;
      int    margin;
      int    lowconf;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   argmax_classifier #(.N_CLASSES(NC)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Ready       (Ready),
      .Probability (prob),
      .Busy        (Busy),
      .Done        (Done),
      .Valid       (Valid),
      .Digit       (Digit),
      .Confidence  (Confidence),
      .Runner      (Runner),
      .Margin      (Margin),
      .LowConf     (LowConf)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input string name, input int n, input int digit, input int conf,
                           input int runner, input int margin, input int lowconf);
      exp_t e;
      e.name  = name;
      e.cyc   = n + NC + 1;
      e.digit = digit;
      e.conf  = conf;
`ifdef ARGMAX_MARGIN_EN
      e.runner  = runner;
      e.margin  = margin;
      e.lowconf = lowconf;
`else
      e.runner  = 0 * runner;
      e.margin  = 0 * margin;
      e.lowconf = 0 * lowconf;
`endif
      exp_q.push_back(e);
   endtask

   task automatic set_elem(input int i, input logic [15:0] v);
      prob[i*16 +: 16] = v;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < NC; i++) set_elem(i, v);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge Clk);
   endtask

   // Ready sampled high at edge n; returns just after that edge with Ready low again.
   task automatic start_scan(output int n);
      @(negedge Clk);
      Ready = 1'b1;
      n = cyc + 1;
      @(negedge Clk);
      Ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, Busy, 0);
      check({tag, "_done"}, Done, 0);
      check({tag, "_valid"}, Valid, 0);
      check({tag, "_digit"}, Digit, 0);
      check({tag, "_conf"}, Confidence, 0);
      check({tag, "_runner"}, Runner, 0);
      check({tag, "_margin"}, Margin, 0);
      check({tag, "_lowconf"}, LowConf, 0);
   endtask

   always @(negedge Clk) begin
      if (!Reset && Done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            $display("[TB] txn %s: cycle %0d digit %0d conf %0d runner %0d margin %0d lowconf %0d",
                     mon_e.name, cyc, Digit, Confidence, Runner, Margin, LowConf);
            check({mon_e.name, "_latency"}, cyc, mon_e.cyc);
            check({mon_e.name, "_digit"}, Digit, mon_e.digit);
            check({mon_e.name, "_conf"}, Confidence, mon_e.conf);
            check({mon_e.name, "_runner"}, Runner, mon_e.runner);
            check({mon_e.name, "_margin"}, Margin, mon_e.margin);
            check({mon_e.name, "_lowconf"}, LowConf, mon_e.lowconf);
            check({mon_e.name, "_valid"}, Valid, 1);
            check({mon_e.name, "_busy"}, Busy, 0);
         end
      end
   end

   initial begin
      int n;
      int guard;

      repeat (3) @(negedge Clk);
      check_all_zero("reset");

      // Ascending values; Ready already high while in reset counts as a start.
      for (int i = 0; i < NC; i++) set_elem(i, 16'((i + 1) * 100));
      Ready = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n = cyc + 1;
      push_exp("ascending", n, 9, 1000, 8, 100, 1);
      @(negedge Clk);
      Ready = 1'b0;
      check("asc_busy_after_start", Busy, 1);
      wait_until(n + NC + 3);
      check("asc_valid_held", Valid, 1);
      check("asc_busy_idle", Busy, 0);

      // All equal: ties resolve to lowest index.
      set_all(16'h0700);
      start_scan(n);
      push_exp("all_equal", n, 0, 16'h0700, 1, 0, 0);
      check("eq_valid_cleared", Valid, 0);
      check("eq_busy", Busy, 1);
      wait_until(n + NC + 3);

      // Tied maxima at 3 and 7.
      set_all(16'h0010);
      set_elem(3, 16'h07F0);
      set_elem(7, 16'h07F0);
      start_scan(n);
      push_exp("tie_3_7", n, 3, 16'h07F0, 7, 0, 0);
      wait_until(n + NC + 3);

      // Input change and second Ready pulse during the scan must be ignored.
      for (int i = 0; i < NC; i++) set_elem(i, 16'((NC - i) * 100));
      start_scan(n);
      push_exp("snapshot", n, 0, 1000, 1, 100, 1);
      set_all(16'h07FF);
      wait_until(n + 3);
      Ready = 1'b1;
      @(negedge Clk);
      Ready = 1'b0;
      wait_until(n + 30);
      check("snap_idle_after", Busy, 0);

      // Reset mid-scan aborts without a Done.
      for (int i = 0; i < NC; i++) set_elem(i, 16'((i + 1) * 100));
      start_scan(n);
      wait_until(n + 4);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check_all_zero("abort");
      wait_until(n + 25);
      check("abort_still_idle", Busy, 0);

      // Fresh scan exercising the full unsigned range.
      set_all(16'h0100);
      set_elem(2, 16'h8000);
      set_elem(5, 16'hFFFF);
      start_scan(n);
      push_exp("unsigned_top", n, 5, 16'hFFFF, 2, 16'h7FFF, 0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 60) begin
         @(negedge Clk);
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
      repeat (5) @(negedge Clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
